counter_ctrl: RTL
=================

# counter_ctrl

Sequencing controller for the team's synchronous binary counter datapath. It starts, pauses, aborts and terminates a count run against a programmable terminal value, in one-shot or periodic mode. It reports progress through a busy flag, a per-terminal tick and an end-of-run done pulse. It sits between the test or system sequencer that issues START/ABORT and the counter flops it drives.

## Interface
- WIDTH, 4, counter width in bits; LIMIT and Q share it.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high; a single clock, no other reset.
- START  in  1  begin run; sampled only in IDLE.
- LIMIT  in  WIDTH  terminal count; captured into lim_r on an accepted START.
- MODE  in  1  0 = one-shot, 1 = periodic; captured into mode_r on an accepted START.
- PAUSE  in  1  level; while high in RUN, the count holds.
- ABORT  in  1  pulse or level; forces return to IDLE.
- Q  out  WIDTH  current count.
- BUSY  out  1  high in RUN.
- TICK  out  1  combinational; high in the cycle whose closing edge is a terminal edge.
- DONE  out  1  registered; one-cycle pulse at one-shot completion.

## Operation
- States: IDLE, RUN, FIN.
- Reset values (edge with RST=1):
  - state=IDLE, Q=0, lim_r=0, mode_r=0.
  - BUSY=0, TICK=0, DONE=0.
- Priority at every edge: RST > ABORT > state logic > PAUSE.
- IDLE:
  - Q holds 0.
  - START=1 and ABORT=0: capture LIMIT into lim_r and MODE into mode_r, Q<=0, go to RUN.
- RUN, ABORT=0, PAUSE=1: Q, lim_r and state hold. TICK=0.
- RUN, ABORT=0, PAUSE=0, Q!=lim_r: Q<=Q+1. TICK=0.
- RUN, ABORT=0, PAUSE=0, Q==lim_r (terminal): TICK=1 this cycle.
  - mode_r=1: Q<=0, stay in RUN.
  - mode_r=0: Q holds lim_r, go to FIN.
- FIN:
  - DONE=1 and Q=lim_r for exactly one cycle.
  - Next edge: Q<=0, go to IDLE.
  - START in FIN is ignored and not queued.
- ABORT in any state: Q<=0, go to IDLE next edge. No TICK or DONE is generated for that cycle.
- START outside IDLE: ignored. LIMIT/MODE changes during a run have no effect.
- Arithmetic: Q is unsigned, width WIDTH. Q never exceeds lim_r, so there is no natural overflow.
  - lim_r = 2^WIDTH−1 is legal and counts the full range.

## Timing
- Start latency: START accepted at edge k puts RUN active after edge k with Q=0. The first increment happens at edge k+1.
- One-shot run with lim_r=N and no pause:
  - TICK high in cycle N after entry, i.e. while Q=N.
  - DONE high in the following cycle.
  - BUSY low and Q=0 one cycle after that.
  - Total from START edge to IDLE is N+2 edges.
- Periodic run: TICK every N+1 unpaused RUN cycles. Q sequence is 0..N,0..
- lim_r=0:
  - Periodic: TICK high every unpaused cycle, Q stays 0.
  - One-shot: TICK in the first RUN cycle, DONE the next.
- PAUSE and terminal coincide: PAUSE wins. No TICK; terminal action is deferred until PAUSE drops.
- ABORT and terminal coincide: ABORT wins. TICK=0, no FIN.
- RST mid-run: next cycle fully reset; a pending DONE is lost.

## Structure
- Shared package counter_pkg holds:
  - state encoding constants: IDLE=2'b00, RUN=2'b01, FIN=2'b10;
  - the MODE encodings ONESHOT=1'b0, PERIODIC=1'b1.
  - 2'b11 is illegal; it must recover to IDLE on the next edge.
- One sub-module: sync_counter_en (CLK, RST, CLR, EN, Q).
  - Synchronous WIDTH-bit up counter with sync clear; CLR has priority over EN.
  - The controller drives CLR and EN; it does not write Q directly.
- FSM, lim_r/mode_r capture registers and compare logic live in counter_ctrl.

## Test plan
- Reset then idle: RST high 2 cycles, then hold START=0 for 5 cycles -> Q=0, BUSY=0, TICK=0, DONE=0 throughout.
- One-shot: START with LIMIT=5, MODE=0 -> Q goes 0,1,2,3,4,5; TICK in the Q=5 cycle; DONE the next cycle; IDLE with Q=0 after 7 edges total; exactly one DONE.
- Periodic wrap: LIMIT=15, MODE=1, run 40 cycles -> Q wraps 15→0; TICK at cycles 15 and 31 after entry; DONE never asserted.
- Pause at terminal: LIMIT=3, MODE=0, PAUSE high from the Q=3 cycle for 4 cycles -> Q stays 3, TICK=0 while paused; TICK on the first unpaused cycle, then DONE.
- Abort collisions: ABORT together with the terminal cycle (LIMIT=2) -> no TICK, no DONE, Q=0, IDLE. Separately, START+ABORT in IDLE -> remains IDLE.
- Edge cases: LIMIT=0 one-shot -> TICK then DONE on consecutive cycles. START asserted during RUN or FIN with a new LIMIT -> ignored; the original lim_r is still honoured.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the counter sequencing controller.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  localparam logic ONESHOT  = 1'b0;
  localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/sync_counter_en.sv
// WIDTH-bit synchronous up counter; synchronous clear has priority over enable.
module sync_counter_en #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             EN,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (CLR) begin
      q_d = '0;
    end else if (EN) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/counter_ctrl.sv
// Run sequencer for a binary counter: start/pause/abort, one-shot or periodic
// against a captured terminal value. Exposes FSM state on DBG_STATE.
//
// Handshake: START is a request sampled only in IDLE; it is accepted on the
// edge where state is IDLE, START=1 and ABORT=0, with no back-pressure. ABORT
// wins over everything except RST, and PAUSE yields to all other controls.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] LIMIT,
  input  logic             MODE,
  input  logic             PAUSE,
  input  logic             ABORT,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             TICK,
  output logic             DONE,
  output logic [1:0]       DBG_STATE
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_en;
  logic [WIDTH-1:0] cnt_q;
  logic             run_step;
  logic             term_hit;

  // An unpaused, unaborted RUN cycle; at the terminal value it is a tick.
  assign run_step = (state_q == RUN) && !ABORT && !PAUSE;
  assign term_hit = run_step && (cnt_q == lim_q);

  sync_counter_en #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .CLK(CLK),
    .RST(RST),
    .CLR(cnt_clr),
    .EN (cnt_en),
    .Q  (cnt_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      lim_q   <= '0;
      mode_q  <= ONESHOT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (ABORT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            lim_d   = LIMIT;
            mode_d  = MODE;
            state_d = RUN;
          end
        end
        RUN: begin
          if (term_hit && (mode_q == ONESHOT)) begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter is cleared everywhere except while RUN holds or advances it;
  // a one-shot terminal leaves it holding lim_r for the FIN cycle.
  always_comb begin
    cnt_en    = run_step && (cnt_q != lim_q);
    cnt_clr   = ABORT || (state_q != RUN) || (term_hit && (mode_q == PERIODIC));
    BUSY      = (state_q == RUN);
    TICK      = term_hit;
    DONE      = done_q;
    DBG_STATE = state_q;
    Q         = cnt_q;
  end

endmodule
